// File: rtl/kfx86_iterative_shifter_if.sv
// Operand/result bundle between the execution sequencer and the iterative shifter.
interface kfx86_iterative_shifter_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int COUNT_WIDTH = 8
);
   logic                   start;
   logic [2:0]             opcode;
   logic                   select_word;
   logic [DATA_WIDTH-1:0]  source;
   logic [COUNT_WIDTH-1:0] count;
   logic [5:0]             flags_in;
   logic                   busy;
   logic                   done;
   logic [DATA_WIDTH-1:0]  result;
   logic [5:0]             flags_out;

   modport master (
      output start, opcode, select_word, source, count, flags_in,
      input  busy, done, result, flags_out
   );

   modport slave (
      input  start, opcode, select_word, source, count, flags_in,
      output busy, done, result, flags_out
   );
endinterface

// File: rtl/kfx86_iterative_shifter.sv
// Multi-cycle shift/rotate unit (ROL/ROR/RCL/RCR/SHL/SHR/SAR), one bit-step per clock.
// Define KFX86_SHIFT_COUNT_MASK_EN to mask the count to 5 bits (80186+ behaviour).
module kfx86_iterative_shifter #(
   parameter int DATA_WIDTH  = 16,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                      clock,
   input  logic                      reset_n,
   kfx86_iterative_shifter_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [2:0] {
      OP_ROL = 3'd0, OP_ROR = 3'd1, OP_RCL = 3'd2, OP_RCR = 3'd3,
      OP_SHL = 3'd4, OP_SHR = 3'd5, OP_SAL = 3'd6, OP_SAR = 3'd7
   } op_t;

   state_t                 state_q, state_d;
   op_t                    op_q;
   logic                   word_q;
   logic [DATA_WIDTH-1:0]  val_q;
   logic                   c_q;
   logic [COUNT_WIDTH-1:0] n_q;
   logic [5:0]             fl_q;
   logic [DATA_WIDTH-1:0]  result_q;
   logic [5:0]             flags_q;

   logic [COUNT_WIDTH-1:0] n_eff;
   logic [DATA_WIDTH-1:0]  src_masked;
   logic [DATA_WIDTH-1:0]  top_bit, shl_base, shr_base;
   logic [DATA_WIDTH-1:0]  step_val;
   logic                   msb, step_c, step_o, new_msb, new_msb1, is_shift;
   logic [5:0]             step_flags;

`ifdef KFX86_SHIFT_COUNT_MASK_EN
   assign n_eff = bus.count & COUNT_WIDTH'(5'h1F);
`else
   assign n_eff = bus.count;
`endif

   // Byte operands are zero-extended on capture, so every step can work on the full register.
   assign src_masked = bus.select_word ? bus.source : DATA_WIDTH'(bus.source[7:0]);

   always_comb begin
      msb      = word_q ? val_q[DATA_WIDTH-1] : val_q[7];
      top_bit  = word_q ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : DATA_WIDTH'(8'h80);
      shl_base = word_q ? {val_q[DATA_WIDTH-2:0], 1'b0} : DATA_WIDTH'({val_q[6:0], 1'b0});
      shr_base = val_q >> 1;
      step_val = shl_base;
      step_c   = msb;
      case (op_q)
         OP_ROL: begin
            step_val = shl_base | DATA_WIDTH'(msb);
            step_c   = msb;
         end
         OP_ROR: begin
            step_val = shr_base | (val_q[0] ? top_bit : '0);
            step_c   = val_q[0];
         end
         OP_RCL: begin
            step_val = shl_base | DATA_WIDTH'(c_q);
            step_c   = msb;
         end
         OP_RCR: begin
            step_val = shr_base | (c_q ? top_bit : '0);
            step_c   = val_q[0];
         end
         OP_SHL, OP_SAL: begin
            step_val = shl_base;
            step_c   = msb;
         end
         OP_SHR: begin
            step_val = shr_base;
            step_c   = val_q[0];
         end
         OP_SAR: begin
            step_val = shr_base | (msb ? top_bit : '0);
            step_c   = val_q[0];
         end
         default: ;
      endcase

      new_msb  = word_q ? step_val[DATA_WIDTH-1] : step_val[7];
      new_msb1 = word_q ? step_val[DATA_WIDTH-2] : step_val[6];
      case (op_q)
         OP_ROR, OP_RCR: step_o = new_msb ^ new_msb1;
         OP_SHR:         step_o = msb;
         OP_SAR:         step_o = 1'b0;
         default:        step_o = step_c ^ new_msb;
      endcase

      is_shift = op_q[2];
      if (is_shift)
         step_flags = {step_o, new_msb, (step_val == '0), fl_q[2], ~^step_val[7:0], step_c};
      else
         step_flags = {step_o, fl_q[4], fl_q[3], fl_q[2], fl_q[1], step_c};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = (n_eff == '0) ? S_DONE : S_RUN;
         S_RUN:   if (n_q == COUNT_WIDTH'(1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_q     <= OP_ROL;
         word_q   <= 1'b0;
         val_q    <= '0;
         c_q      <= 1'b0;
         n_q      <= '0;
         fl_q     <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (bus.start) begin
               op_q   <= op_t'(bus.opcode);
               word_q <= bus.select_word;
               val_q  <= src_masked;
               c_q    <= bus.flags_in[0];
               fl_q   <= bus.flags_in;
               n_q    <= n_eff;
               if (n_eff == '0) begin
                  result_q <= src_masked;
                  flags_q  <= bus.flags_in;
               end
            end
            S_RUN: begin
               val_q <= step_val;
               c_q   <= step_c;
               n_q   <= n_q - COUNT_WIDTH'(1);
               if (n_q == COUNT_WIDTH'(1)) begin
                  result_q <= step_val;
                  flags_q  <= step_flags;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.result    = result_q;
   assign bus.flags_out = flags_q;

endmodule

// File: tb/tb_kfx86_iterative_shifter.sv
// Self-checking bench for kfx86_iterative_shifter: directed cases, random ops against an arithmetic model, busy/abort handling.
module tb_kfx86_iterative_shifter;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   kfx86_iterative_shifter_if #(.DATA_WIDTH(16), .COUNT_WIDTH(8)) sif ();

   kfx86_iterative_shifter #(.DATA_WIDTH(16), .COUNT_WIDTH(8)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (sif)
   );

   always #5 clock = ~clock;

   function automatic int eff_count(input int cnt);
`ifdef KFX86_SHIFT_COUNT_MASK_EN
      return cnt & 31;
`else
      return cnt;
`endif
   endfunction

   // Reference: whole-operation arithmetic on the operand, not a step-by-step replay.
   function automatic void model(input int op, input bit word, input logic [15:0] src,
                                 input logic [5:0] fin, input int n,
                                 output logic [15:0] res, output logic [5:0] fout);
      int w, k, len;
      logic [63:0] mask, v, r, ring, rmask;
      bit c, o, sign;
      w    = word ? 16 : 8;
      mask = (64'd1 << w) - 64'd1;
      v    = {48'd0, src} & mask;
      if (n == 0) begin
         res  = v[15:0];
         fout = fin;
         return;
      end
      sign  = v[w-1];
      len   = w + 1;
      rmask = (64'd1 << len) - 64'd1;
      ring  = ({63'd0, fin[0]} << w) | v;
      r = 0; c = 0; o = 0;
      case (op)
         0: begin
            k = n % w;
            r = ((v << k) | (v >> (w - k))) & mask;
            c = r[0];
            o = c ^ r[w-1];
         end
         1: begin
            k = n % w;
            r = ((v >> k) | (v << (w - k))) & mask;
            c = r[w-1];
            o = r[w-1] ^ r[w-2];
         end
         2: begin
            k = n % len;
            ring = ((ring << k) | (ring >> (len - k))) & rmask;
            r = ring & mask;
            c = ring[w];
            o = c ^ r[w-1];
         end
         3: begin
            k = n % len;
            ring = ((ring >> k) | (ring << (len - k))) & rmask;
            r = ring & mask;
            c = ring[w];
            o = r[w-1] ^ r[w-2];
         end
         4, 6: begin
            if (n <= w) begin
               r = (v << n) & mask;
               c = v[w-n];
            end
            o = c ^ r[w-1];
         end
         5: begin
            if (n <= w) begin
               r = v >> n;
               c = v[n-1];
            end
            o = (n == 1) ? sign : 1'b0;
         end
         default: begin
            if (n >= w) begin
               r = sign ? mask : 64'd0;
               c = sign;
            end else begin
               r = (v >> n) | (sign ? (mask & ~(mask >> n)) : 64'd0);
               c = v[n-1];
            end
            o = 1'b0;
         end
      endcase
      res = r[15:0];
      if (op >= 4)
         fout = {o, r[w-1], (r == 0), fin[2], ~^r[7:0], c};
      else
         fout = {o, fin[4], fin[3], fin[2], fin[1], c};
   endfunction

   // Drives one request from #1 after an edge and waits for done; reports edges to done.
   task automatic launch(input logic [2:0] op, input logic word, input logic [15:0] src,
                         input logic [7:0] cnt, input logic [5:0] fin,
                         output int cycles, output bit timed_out);
      sif.opcode      = op;
      sif.select_word = word;
      sif.source      = src;
      sif.count       = cnt;
      sif.flags_in    = fin;
      sif.start       = 1'b1;
      cycles    = 0;
      timed_out = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(posedge clock); #1;
         sif.start = 1'b0;
         cycles++;
         if (sif.done === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #1;
      n_checks++;
      if ({sif.busy, sif.done} !== 2'b00 || sif.result !== 16'h0000 || sif.flags_out !== 6'h00) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b result=%h flags=%h, want 0/0/0000/00",
                  sif.busy, sif.done, sif.result, sif.flags_out);
      end
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_directed;
      logic [2:0]  t_op  [6] = '{3'd4, 3'd1, 3'd7, 3'd2, 3'd5, 3'd3};
      logic        t_w   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [15:0] t_src [6] = '{16'h8001, 16'hFF01, 16'h0080, 16'h8000, 16'h1234, 16'h1234};
      logic [7:0]  t_cnt [6] = '{8'd1, 8'd3, 8'd2, 8'd33, 8'd0, 8'd0};
      logic [5:0]  t_fin [6] = '{6'h00, 6'h1E, 6'h00, 6'h00, 6'h2A, 6'h2A};
`ifdef KFX86_SHIFT_COUNT_MASK_EN
      int          t_lat [6] = '{2, 4, 3, 2, 1, 1};
      logic [15:0] t_res [6] = '{16'h0002, 16'h0020, 16'h00E0, 16'h0000, 16'h1234, 16'h1234};
      logic [5:0]  t_fl  [6] = '{6'h21, 6'h1E, 6'h10, 6'h21, 6'h2A, 6'h2A};
`else
      int          t_lat [6] = '{2, 4, 3, 34, 1, 1};
      logic [15:0] t_res [6] = '{16'h0002, 16'h0020, 16'h00E0, 16'h4000, 16'h1234, 16'h1234};
      logic [5:0]  t_fl  [6] = '{6'h21, 6'h1E, 6'h10, 6'h00, 6'h2A, 6'h2A};
`endif
      int cycles;
      bit to;
      for (int i = 0; i < 6; i++) begin
         launch(t_op[i], t_w[i], t_src[i], t_cnt[i], t_fin[i], cycles, to);
         n_checks++;
         if (to || cycles != t_lat[i]) begin
            n_fail++;
            $display("FAIL directed_latency[%0d]: took %0d cycles (timeout=%0b), want %0d", i, cycles, to, t_lat[i]);
         end
         n_checks++;
         if (sif.result !== t_res[i] || sif.flags_out !== t_fl[i]) begin
            n_fail++;
            $display("FAIL directed_result[%0d]: result=%h flags=%h, want %h/%h",
                     i, sif.result, sif.flags_out, t_res[i], t_fl[i]);
         end
         @(posedge clock); #1;
         n_checks++;
         if (sif.done !== 1'b0 || sif.busy !== 1'b0 || sif.result !== t_res[i] || sif.flags_out !== t_fl[i]) begin
            n_fail++;
            $display("FAIL directed_hold[%0d]: done=%b busy=%b result=%h flags=%h, want 0/0/%h/%h",
                     i, sif.done, sif.busy, sif.result, sif.flags_out, t_res[i], t_fl[i]);
         end
      end
   endtask

   task automatic test_random;
      logic [2:0]  op;
      logic        w;
      logic [15:0] src, exp_res;
      logic [7:0]  cnt;
      logic [5:0]  fin, exp_fl;
      int cycles, n;
      bit to;
      for (int i = 0; i < 48; i++) begin
         op  = 3'($urandom_range(0, 7));
         w   = 1'($urandom_range(0, 1));
         src = 16'($urandom);
         fin = 6'($urandom);
         cnt = (i % 8 == 7) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
         n   = eff_count(int'(cnt));
         model(int'(op), w, src, fin, n, exp_res, exp_fl);
         launch(op, w, src, cnt, fin, cycles, to);
         n_checks++;
         if (to || cycles != n + 1 || sif.result !== exp_res || sif.flags_out !== exp_fl) begin
            n_fail++;
            $display("FAIL random[%0d] op=%0d w=%0b src=%h cnt=%0d cf=%h: cycles=%0d result=%h flags=%h, want %0d/%h/%h",
                     i, op, w, src, cnt, fin, cycles, sif.result, sif.flags_out, n + 1, exp_res, exp_fl);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_start_while_busy;
      logic [15:0] exp_res;
      logic [5:0]  exp_fl;
      int cycles;
      bit to;
      model(3, 1'b1, 16'h1357, 6'h01, 4, exp_res, exp_fl);
      sif.opcode = 3'd3; sif.select_word = 1'b1; sif.source = 16'h1357;
      sif.count = 8'd4; sif.flags_in = 6'h01; sif.start = 1'b1;
      @(posedge clock); #1;
      sif.start = 1'b0;
      @(posedge clock); #1;
      sif.opcode = 3'd4; sif.select_word = 1'b0; sif.source = 16'hFFFF;
      sif.count = 8'd0; sif.flags_in = 6'h3F; sif.start = 1'b1;
      cycles = 2; to = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         sif.start = 1'b0;
         cycles++;
         if (sif.done === 1'b1) begin
            to = 1'b0;
            break;
         end
      end
      n_checks++;
      if (to || cycles != 5 || sif.result !== exp_res || sif.flags_out !== exp_fl) begin
         n_fail++;
         $display("FAIL busy_ignore: cycles=%0d result=%h flags=%h, want 5/%h/%h",
                  cycles, sif.result, sif.flags_out, exp_res, exp_fl);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_reset_abort;
      logic [15:0] exp_res;
      logic [5:0]  exp_fl;
      int cycles;
      bit to, saw_done;
      launch(3'd4, 1'b1, 16'h00F0, 8'd1, 6'h00, cycles, to);
      n_checks++;
      if (to || sif.result !== 16'h01E0) begin
         n_fail++;
         $display("FAIL abort_setup: result=%h timeout=%0b, want 01e0", sif.result, to);
      end
      @(posedge clock); #1;
      sif.opcode = 3'd5; sif.select_word = 1'b1; sif.source = 16'hABCD;
      sif.count = 8'd5; sif.flags_in = 6'h00; sif.start = 1'b1;
      @(posedge clock); #1;
      sif.start = 1'b0;
      @(posedge clock); #1;
      sif.opcode = 3'd0; sif.count = 8'd0; sif.start = 1'b1;
      n_checks++;
      if (sif.busy !== 1'b1 || sif.done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_running: busy=%b done=%b, want 1/0", sif.busy, sif.done);
      end
      @(posedge clock); #1;
      sif.start = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.result !== 16'h0000 || sif.flags_out !== 6'h00) begin
         n_fail++;
         $display("FAIL abort_async: busy=%b done=%b result=%h flags=%h, want 0/0/0000/00",
                  sif.busy, sif.done, sif.result, sif.flags_out);
      end
      @(posedge clock); @(posedge clock); #1;
      reset_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         if (sif.done !== 1'b0 || sif.busy !== 1'b0) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done) begin
         n_fail++;
         $display("FAIL abort_no_done: activity seen after reset, want none");
      end
      model(5, 1'b1, 16'hABCD, 6'h00, 5, exp_res, exp_fl);
      launch(3'd5, 1'b1, 16'hABCD, 8'd5, 6'h00, cycles, to);
      n_checks++;
      if (to || cycles != 6 || sif.result !== exp_res || sif.flags_out !== exp_fl) begin
         n_fail++;
         $display("FAIL abort_fresh: cycles=%0d result=%h flags=%h, want 6/%h/%h",
                  cycles, sif.result, sif.flags_out, exp_res, exp_fl);
      end
      @(posedge clock); #1;
   endtask

   initial begin
      sif.start = 1'b0; sif.opcode = '0; sif.select_word = 1'b0;
      sif.source = '0; sif.count = '0; sif.flags_in = '0;
      test_reset();
      test_directed();
      test_random();
      test_start_while_busy();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/kfx86_iterative_shifter.md
Name: kfx86_iterative_shifter

Overview:
- Multi-cycle shift/rotate execution unit for the x86 core's "shift by CL" group: ROL, ROR, RCL, RCR, SHL/SAL, SHR, SAR.
- Successor to the single-step combinational shift ops: adds a parametrised data width, a count operand, and a start/busy/done handshake.
- Performs one bit-step per clock.
- Sits beside the combinational ALU; the execution sequencer launches it and waits on done.

Parameters:
- DATA_WIDTH, 16, full operand width in bits (>= 8). Byte mode always uses bits [7:0].
- COUNT_WIDTH, 8, width of the count operand (CL).

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  launch request; accepted only in IDLE.
- opcode  input  3  0 ROL, 1 ROR, 2 RCL, 3 RCR, 4 SHL, 5 SHR, 6 SAL (=SHL), 7 SAR.
- select_word  input  1  1 = full DATA_WIDTH operand, 0 = byte operand.
- source  input  DATA_WIDTH  operand.
- count  input  COUNT_WIDTH  shift count.
- flags_in  input  6  {o,s,z,a,p,c} current flags.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result and flags_out valid during it.
- result  output  DATA_WIDTH  shifted value; byte mode zero-extends above bit 7.
- flags_out  output  6  {o,s,z,a,p,c} updated flags.

Behaviour:
- Reset (async, reset_n=0): state IDLE, busy=0, done=0, result=0, flags_out=0, internal count=0.
- FSM IDLE:
  - On start: latch opcode, select_word, source, flags_in, and effective count N into working registers.
  - N=0 -> DONE; else -> RUN.
- FSM RUN:
  - Each cycle performs one 1-bit step on the working value and working C, then decrements N.
  - When N reaches 0 after a step -> DONE.
- FSM DONE: done=1 for exactly one cycle, then -> IDLE.
- result and flags_out hold their value from done until the next accepted start.
- Latency: start accepted in cycle T gives done in cycle T+N+1. N=0 gives done at T+1.
- start while busy is ignored; operands are not re-sampled.
- Step rules (MSB = bit DATA_WIDTH-1 for word, bit 7 for byte):
  - ROL: C=MSB; value={value,MSB}.
  - ROR: C=bit0; value={bit0,value}.
  - RCL: 9-/(DATA_WIDTH+1)-bit ring through C, rotating left.
  - RCR: same ring, rotating right.
  - SHL: C=MSB; 0 shifted in at bit 0.
  - SHR: C=bit0; 0 shifted in at MSB.
  - SAR: C=bit0; MSB replicated.
- Overflow (O), from the final step only:
  - ROL/RCL/SHL: O = C xor new MSB.
  - ROR/RCR: O = new MSB xor new MSB-1.
  - SHR: O = MSB of the operand before the final step.
  - SAR: O = 0.
- S/Z/P:
  - Shifts (SHL/SAL/SHR/SAR) with N>0: S=MSB; Z=1 if the width-masked result is 0; P = even parity of bits [7:0].
  - Rotates: S, Z, P unchanged.
- A is always passed through unchanged.
- N=0: result=source (width-masked), flags_out=flags_in.
- Byte mode: bits above 7 of source are ignored and result[DATA_WIDTH-1:8]=0.
- Counts larger than the width are honoured literally:
  - Shifts saturate to all-0, or all-sign for SAR.
  - Rotates wrap modulo ring length, but still take N cycles.
- reset_n low in any state aborts immediately to reset values; no done pulse is produced.

Optional Feature:
- KFX86_SHIFT_COUNT_MASK_EN defined:
  - Effective N = count & 5'h1F (80186+ behaviour).
  - Maximum latency is 32 cycles.
- Undefined:
  - N = full count (8088 behaviour).
  - Maximum latency is 2^COUNT_WIDTH cycles.

Test Plan:
- SHL word, source=16'h8001, count=1, flags_in=0 -> done at T+2, result=16'h0002, C=1, O=1, S=0, Z=0, P=0.
- ROR byte, source=16'hFF01, count=3 -> done at T+4, result=16'h0020, C=0, O=0; S/Z/P equal flags_in.
- SAR byte, source=8'h80, count=2 -> result=16'h00E0, C=0, O=0, S=1, Z=0, P=0.
- RCL word, source=16'h8000, C_in=0, count=33:
  - Unmasked -> done at T+34, result=16'h4000, C=0.
  - KFX86_SHIFT_COUNT_MASK_EN defined -> done at T+2, result=16'h0000, C=1.
- count=0, any op, source=16'h1234, flags_in=6'h2A -> done at T+1, result=16'h1234, flags_out=6'h2A.
- Issue SHR count=5, pulse start again at T+2, then drop reset_n at T+3:
  - Second start is ignored.
  - busy, done and result go to 0 asynchronously.
  - No done pulse follows.
  - A fresh start after reset completes normally.
